// File: rtl/game_pkg.sv
// Shared types for the colour-marker detector: quadrant codes, RGB565 field
// positions and the detector FSM states.
package game_pkg;

  // The quadrant code is {bottom_half, right_half}, which matches the region encoding the game FSM uses.
  typedef enum logic [1:0] {
    Q_LT = 2'd0,
    Q_RT = 2'd1,
    Q_LB = 2'd2,
    Q_RB = 2'd3
  } quad_e;

  localparam int R5_MSB = 15;
  localparam int R5_LSB = 11;
  localparam int G6_MSB = 10;
  localparam int G6_LSB = 5;
  localparam int B5_MSB = 4;
  localparam int B5_LSB = 0;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } det_state_e;

endpackage

// File: rtl/color_quad_detector_if.sv
// Camera pixel stream: frame sync, pixel qualifier, coordinates and RGB565 data.
interface color_quad_detector_if;
  logic        vsync;
  logic        de;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [15:0] pixel;

  modport master (output vsync, de, x, y, pixel);
  modport slave  (input  vsync, de, x, y, pixel);
endinterface

// File: rtl/quad_hit_counter.sv
// Saturating per-quadrant hit counter. A frame boundary clears it, or loads 1
// when a hit arrives in the same cycle.
module quad_hit_counter #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  input  logic             load_one,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load_one)
      cnt <= CNT_W'(1);
    else if (clear)
      cnt <= '0;
    else if (inc && cnt != '1)
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/color_quad_detector.sv
// Per-frame colour-marker detector: classifies pixels, counts hits per quadrant
// and updates hysteresis detect flags at each frame boundary.
module color_quad_detector
  import game_pkg::*;
#(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int CNT_W  = 17,
  parameter int R_MIN  = 20,
  parameter int G_MAX  = 24,
  parameter int B_MAX  = 12,
  parameter int ON_TH  = 400,
  parameter int OFF_TH = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  color_quad_detector_if.slave  pix,
  output logic                  detect_LT,
  output logic                  detect_RT,
  output logic                  detect_LB,
  output logic                  detect_RB,
  output logic                  frame_tick,
  input  logic [1:0]            dbg_sel,
  output logic [CNT_W-1:0]      dbg_cnt
);

  localparam logic [9:0]       H_LIM   = 10'(H_RES);
  localparam logic [9:0]       V_LIM   = 10'(V_RES);
  localparam logic [9:0]       H_MID   = 10'(H_RES / 2);
  localparam logic [9:0]       V_MID   = 10'(V_RES / 2);
  localparam logic [4:0]       R_MIN5  = 5'(R_MIN);
  localparam logic [5:0]       G_MAX6  = 6'(G_MAX);
  localparam logic [4:0]       B_MAX5  = 5'(B_MAX);
  localparam logic [CNT_W-1:0] ON_CNT  = CNT_W'(ON_TH);
  localparam logic [CNT_W-1:0] OFF_CNT = CNT_W'(OFF_TH);

  logic             vs_d, vs_rise;
  logic             hit_c, hit_q;
  quad_e            quad_c, quad_q;
  det_state_e       state, state_nxt;
  logic             snap_en, cnt_clr;
  logic [CNT_W-1:0] cnt  [4];
  logic [CNT_W-1:0] snap [4];
  logic [3:0]       det;

  assign hit_c = pix.de && (pix.x < H_LIM) && (pix.y < V_LIM)
              && (pix.pixel[R5_MSB:R5_LSB] >= R_MIN5)
              && (pix.pixel[G6_MSB:G6_LSB] <= G_MAX6)
              && (pix.pixel[B5_MSB:B5_LSB] <= B_MAX5);
  assign quad_c = quad_e'({pix.y >= V_MID, pix.x >= H_MID});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_d    <= 1'b0;
      vs_rise <= 1'b0;
      hit_q   <= 1'b0;
      quad_q  <= Q_LT;
    end else begin
      vs_d    <= pix.vsync;
      vs_rise <= pix.vsync & ~vs_d;
      hit_q   <= hit_c;
      quad_q  <= quad_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SYNC;
    else       state <= state_nxt;
  end

  // The first boundary after reset only clears: that frame was seen partially.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_nxt = state;
    snap_en   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      SYNC: begin
        if (vs_rise) begin
          cnt_clr   = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          cnt_clr = 1'b1;
          snap_en = 1'b1;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  for (genvar q = 0; q < 4; q++) begin : g_cnt
    logic inc;
    assign inc = hit_q && (quad_q == quad_e'(q));
    quad_hit_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc),
      .clear    (cnt_clr),
      .load_one (cnt_clr && inc),
      .cnt      (cnt[q])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the snapshot array is four flops per bit, not a RAM, so it is reset like any register.
      for (int q = 0; q < 4; q++) snap[q] <= '0;
      det        <= '0;
      frame_tick <= 1'b0;
      dbg_cnt    <= '0;
    end else begin
      frame_tick <= snap_en;
      dbg_cnt    <= snap[dbg_sel];
      if (snap_en) begin
        for (int q = 0; q < 4; q++) begin
          snap[q] <= cnt[q];
          // Between OFF and ON the flag keeps its previous value.
          if (cnt[q] >= ON_CNT)
            det[q] <= 1'b1;
          else if (cnt[q] < OFF_CNT)
            det[q] <= 1'b0;
        end
      end
    end
  end

  assign detect_LT = det[Q_LT];
  assign detect_RT = det[Q_RT];
  assign detect_LB = det[Q_LB];
  assign detect_RB = det[Q_RB];

endmodule

// File: tb/tb_color_quad_detector.sv
// Self-checking bench for color_quad_detector: a frame-level model predicts flags,
// frame_tick and dbg_cnt every cycle; directed literal checks pin the model.
module tb_color_quad_detector;
  import game_pkg::*;

  localparam int H_RES = 320, V_RES = 240, CNT_W = 17;
  localparam int R_MIN = 20, G_MAX = 24, B_MAX = 12, ON_TH = 400, OFF_TH = 200;
  localparam logic [15:0] RED = 16'hF800;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       dbg_sel = 2'd0;
  logic             detect_LT, detect_RT, detect_LB, detect_RB, frame_tick;
  logic [CNT_W-1:0] dbg_cnt;

  color_quad_detector_if bus ();

  color_quad_detector #(
    .H_RES(H_RES), .V_RES(V_RES), .CNT_W(CNT_W), .R_MIN(R_MIN), .G_MAX(G_MAX),
    .B_MAX(B_MAX), .ON_TH(ON_TH), .OFF_TH(OFF_TH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix        (bus),
    .detect_LT  (detect_LT),
    .detect_RT  (detect_RT),
    .detect_LB  (detect_LB),
    .detect_RB  (detect_RB),
    .frame_tick (frame_tick),
    .dbg_sel    (dbg_sel),
    .dbg_cnt    (dbg_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct packed {
    int              due;
    logic [3:0][31:0] cnt;
  } upd_t;

  int   cyc = 0;
  logic [1:0] sel_at_edge = 2'd0;
  bit   in_frame = 0;
  bit   prev_vs = 0;
  int   acc [4];
  int   exp_snap [4];
  bit   exp_flag [4];
  upd_t upd_q [$];
  int   tick_count = 0;

  function automatic bit model_hit(input logic d, input int xx, input int yy, input logic [15:0] p);
    return d && xx < H_RES && yy < V_RES &&
           int'(p[15:11]) >= R_MIN && int'(p[10:5]) <= G_MAX && int'(p[4:0]) <= B_MAX;
  endfunction

  function automatic int model_quad(input int xx, input int yy);
    return (yy >= V_RES / 2 ? 2 : 0) + (xx >= H_RES / 2 ? 1 : 0);
  endfunction

  task automatic model_clear();
    in_frame = 0;
    prev_vs  = 0;
    for (int q = 0; q < 4; q++) begin
      acc[q] = 0; exp_snap[q] = 0; exp_flag[q] = 0;
    end
    upd_q.delete();
  endtask

  always @(posedge clk) begin
    cyc++;
    sel_at_edge = dbg_sel;
  end

  always @(negedge clk) begin
    if (frame_tick === 1'b1) tick_count++;
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [31:0] exp_dbg;
    bit          tick;
    if (reset === 1'b0) begin
      exp_dbg = 32'(exp_snap[sel_at_edge]);
      tick = 0;
      if (upd_q.size() > 0 && upd_q[0].due == cyc) begin
        for (int q = 0; q < 4; q++) begin
          exp_snap[q] = int'(upd_q[0].cnt[q]);
          if (exp_snap[q] >= ON_TH)      exp_flag[q] = 1;
          else if (exp_snap[q] < OFF_TH) exp_flag[q] = 0;
        end
        tick = 1;
        void'(upd_q.pop_front());
      end
      check("flags{RB,LB,RT,LT,tick}",
            32'({detect_RB, detect_LB, detect_RT, detect_LT, frame_tick}),
            32'({exp_flag[3], exp_flag[2], exp_flag[1], exp_flag[0], tick}));
      check("dbg_cnt", 32'(dbg_cnt), exp_dbg);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic vs, input logic d, input int xx, input int yy, input logic [15:0] p);
    upd_t u;
    @(posedge clk); #1;
    bus.vsync = vs; bus.de = d; bus.x = 10'(xx); bus.y = 10'(yy); bus.pixel = p;
    // A rising vsync closes the frame before the pixel that comes with it is counted.
    if (vs && !prev_vs) begin
      if (in_frame) begin
        u.due = cyc + 2;
        for (int q = 0; q < 4; q++) u.cnt[q] = 32'(acc[q]);
        upd_q.push_back(u);
      end
      in_frame = 1;
      for (int q = 0; q < 4; q++) acc[q] = 0;
    end
    prev_vs = vs;
    if (model_hit(d, xx, yy, p) && acc[model_quad(xx, yy)] < (1 << CNT_W) - 1)
      acc[model_quad(xx, yy)]++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 16'h0000);
  endtask

  task automatic quad_pixels(input int q, input int n, input logic [15:0] p);
    for (int i = 0; i < n; i++)
      drive(0, 1, (q % 2) * (H_RES / 2) + (i % (H_RES / 2)), (q / 2) * (V_RES / 2) + i / (H_RES / 2), p);
  endtask

  task automatic vs_pulse();
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 16'h0000);
    idle(4);
  endtask

  task automatic set_sel(input logic [1:0] s);
    dbg_sel = s;
    idle(2);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.vsync = 0; bus.de = 0; bus.x = '0; bus.y = '0; bus.pixel = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Run one RB frame, then pin detect_RB and the RB count with literals.
  task automatic rb_frame(input int n, input logic exp_rb);
    quad_pixels(int'(Q_RB), n, RED);
    vs_pulse();
    check("hyst detect_RB", 32'(detect_RB), 32'(exp_rb));
    check("hyst dbg_cnt RB", 32'(dbg_cnt), 32'(n));
  endtask

  initial begin
    int t0;
    bus.vsync = 0; bus.de = 0; bus.x = '0; bus.y = '0; bus.pixel = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset flags+tick", 32'({detect_RB, detect_LB, detect_RT, detect_LT, frame_tick}), 32'd0);
    check("reset dbg_cnt", 32'(dbg_cnt), 32'd0);

    // Two full LT frames: the first boundary is discarded.
    quad_pixels(int'(Q_LT), 19200, RED);
    vs_pulse();
    check("first vsync no tick", 32'(tick_count), 32'd0);
    quad_pixels(int'(Q_LT), 19200, RED);
    vs_pulse();
    set_sel(2'd0);
    check("frame2 tick count", 32'(tick_count), 32'd1);
    check("frame2 flags", 32'({detect_RB, detect_LB, detect_RT, detect_LT}), 32'b0001);
    check("frame2 dbg_cnt LT", 32'(dbg_cnt), 32'd19200);

    // Hysteresis on RB, including both thresholds exactly.
    set_sel(2'd3);
    rb_frame(400, 1'b1);
    rb_frame(300, 1'b1);
    rb_frame(150, 1'b0);
    rb_frame(200, 1'b0);
    rb_frame(399, 1'b0);
    rb_frame(400, 1'b1);
    rb_frame(200, 1'b1);
    rb_frame(199, 1'b0);

    // Non-hits: out of range, de low, wrong colour.
    for (int i = 0; i < 30; i++) drive(0, 1, 400, 10 + i, RED);
    for (int i = 0; i < 30; i++) drive(0, 0, 10 + i, 10, RED);
    for (int i = 0; i < 10; i++) drive(0, 1, 300, 240 + i, RED);
    for (int i = 0; i < 20; i++) drive(0, 1, i, 3, 16'h07E0);
    for (int i = 0; i < 20; i++) drive(0, 1, i, 4, 16'hF81F);
    vs_pulse();
    set_sel(2'd0);
    check("no-hit dbg_cnt LT", 32'(dbg_cnt), 32'd0);
    set_sel(2'd1);
    check("no-hit dbg_cnt RT", 32'(dbg_cnt), 32'd0);

    // Quadrant split and colour threshold edges.
    drive(0, 1, 159, 119, RED);
    drive(0, 1, 160, 120, RED);
    drive(0, 1, 319, 239, RED);
    drive(0, 1, 200, 50, 16'hA30C);
    drive(0, 1, 201, 50, 16'h9B0C);
    drive(0, 1, 202, 50, 16'hA32C);
    drive(0, 1, 203, 50, 16'hA30D);
    vs_pulse();
    set_sel(2'd1);
    check("edge dbg_cnt RT", 32'(dbg_cnt), 32'd1);
    set_sel(2'd3);
    check("edge dbg_cnt RB", 32'(dbg_cnt), 32'd2);
    set_sel(2'd0);
    check("edge dbg_cnt LT", 32'(dbg_cnt), 32'd1);

    // Hit coinciding with the boundary, then vsync held high.
    quad_pixels(int'(Q_LT), 7, RED);
    t0 = tick_count;
    drive(1, 1, 5, 5, RED);
    for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 16'h0000);
    idle(4);
    check("simul snapshot excludes", 32'(dbg_cnt), 32'd7);
    check("held vsync single tick", 32'(tick_count - t0), 32'd1);
    vs_pulse();
    idle(1);
    check("simul next frame starts 1", 32'(dbg_cnt), 32'd1);

    // Reset mid-frame with LT set.
    quad_pixels(int'(Q_LT), 5000, RED);
    vs_pulse();
    check("pre-reset detect_LT", 32'(detect_LT), 32'd1);
    quad_pixels(int'(Q_LT), 5000, RED);
    do_reset();
    check("mid-reset outputs", 32'({detect_RB, detect_LB, detect_RT, detect_LT, frame_tick}), 32'd0);
    check("mid-reset dbg_cnt", 32'(dbg_cnt), 32'd0);
    t0 = tick_count;
    quad_pixels(int'(Q_LT), 500, RED);
    vs_pulse();
    check("post-reset vsync no tick", 32'(tick_count - t0), 32'd0);
    quad_pixels(int'(Q_LT), 500, RED);
    vs_pulse();
    check("post-reset frame tick", 32'(tick_count - t0), 32'd1);
    check("post-reset detect_LT", 32'(detect_LT), 32'd1);
    check("post-reset dbg_cnt", 32'(dbg_cnt), 32'd500);

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
